// File: rtl/tdm_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tdm_buffer_scheduler
// Description : Captures a TDM serial stream into a double-banked frame
//               buffer and hands completed banks over to a host.
//               Optional overrun tracking is enabled by SCHED_OVERRUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_buffer_scheduler #(
    parameter int NUM_FRAMES     = 16,
    parameter int BITS_PER_FRAME = 32
) (
    input  logic                                            clk50,
    input  logic                                            reset_in_rg,
    input  logic                                            c4,
    input  logic                                            f0,
    input  logic                                            data_from_dt,
    input  logic                                            rd_ack,
    input  logic                                            clr_ovr,
    output logic                                            wr_en,
    output logic                                            wr_bank,
    output logic [$clog2(NUM_FRAMES*BITS_PER_FRAME)-1:0]    wr_addr,
    output logic                                            wr_data,
    output logic                                            rd_bank,
    output logic                                            cpu_int,
    output logic                                            overrun
);

    localparam int ADDR_W = $clog2(NUM_FRAMES*BITS_PER_FRAME);
    localparam int HALF_W = $clog2(2*BITS_PER_FRAME);
    localparam int FRM_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    localparam logic [HALF_W-1:0] c_LAST_HALF  = HALF_W'(2*BITS_PER_FRAME-2);
    localparam logic [FRM_W-1:0]  c_LAST_FRAME = FRM_W'(NUM_FRAMES-1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_SWAP    = 2'd2;

    logic [1:0]        r_c4_sync;
    logic [1:0]        r_f0_sync;
    logic [1:0]        r_dat_sync;
    logic              r_c4_prev;

    logic [1:0]        r_state;
    logic [HALF_W-1:0] r_half;
    logic [FRM_W-1:0]  r_frame;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic              r_cpu_int;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_data;

    logic              w_c4_rise;
    logic              w_f0;
    logic              w_dat;

    logic [1:0]        w_state_nxt;
    logic [HALF_W-1:0] w_half_nxt;
    logic [FRM_W-1:0]  w_frame_nxt;
    logic              w_wr_bank_nxt;
    logic              w_rd_bank_nxt;
    logic              w_cpu_int_nxt;
    logic              w_wr;
    logic [HALF_W-1:0] w_count;
    logic [ADDR_W-1:0] w_addr;
    logic              w_ovr_evt;

    // Two-flop synchronizers; the extra c4 stage gives the rising-edge history.
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            r_c4_sync  <= 2'b00;
            r_f0_sync  <= 2'b00;
            r_dat_sync <= 2'b00;
            r_c4_prev  <= 1'b0;
        end else begin
            r_c4_sync  <= {r_c4_sync[0],  c4};
            r_f0_sync  <= {r_f0_sync[0],  f0};
            r_dat_sync <= {r_dat_sync[0], data_from_dt};
            r_c4_prev  <= r_c4_sync[1];
        end
    end

    assign w_c4_rise = r_c4_sync[1] & ~r_c4_prev;
    assign w_f0      = r_f0_sync[1];
    assign w_dat     = r_dat_sync[1];

    always_comb begin
        w_state_nxt   = r_state;
        w_half_nxt    = r_half;
        w_frame_nxt   = r_frame;
        w_wr_bank_nxt = r_wr_bank;
        w_rd_bank_nxt = r_rd_bank;
        w_cpu_int_nxt = r_cpu_int & ~rd_ack;
        w_wr          = 1'b0;
        w_count       = '0;
        w_ovr_evt     = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_half_nxt = '0;
                if (w_c4_rise && w_f0) begin
                    w_wr        = 1'b1;
                    w_half_nxt  = HALF_W'(1);
                    w_state_nxt = c_CAPTURE;
                end
            end

            c_CAPTURE: begin
                if (!w_f0) begin
                    w_state_nxt = c_IDLE;
                    w_half_nxt  = '0;
                end else if (w_c4_rise) begin
                    w_count = r_half;
                    w_wr    = ~r_half[0];
                    if (r_half == c_LAST_HALF) begin
                        w_half_nxt = '0;
                        if (r_frame == c_LAST_FRAME) begin
                            w_frame_nxt = '0;
                            w_state_nxt = c_SWAP;
                        end else begin
                            w_frame_nxt = r_frame + FRM_W'(1);
                        end
                    end else begin
                        w_half_nxt = r_half + HALF_W'(1);
                    end
                end
            end

            c_SWAP: begin
`ifdef SCHED_OVERRUN_EN
                // An acknowledge in this same cycle frees the host before the test.
                if (r_cpu_int && !rd_ack) begin
                    w_ovr_evt = 1'b1;
                end else begin
                    w_rd_bank_nxt = r_wr_bank;
                    w_wr_bank_nxt = ~r_wr_bank;
                    w_cpu_int_nxt = 1'b1;
                end
`else
                w_rd_bank_nxt = r_wr_bank;
                w_wr_bank_nxt = ~r_wr_bank;
                w_cpu_int_nxt = 1'b1;
`endif
                if (w_f0) begin
                    w_state_nxt = c_CAPTURE;
                    if (w_c4_rise) begin
                        w_wr       = 1'b1;
                        w_half_nxt = HALF_W'(1);
                    end
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_half_nxt  = '0;
            end
        endcase
    end

    assign w_addr = ADDR_W'(r_frame) * ADDR_W'(BITS_PER_FRAME) + ADDR_W'(w_count >> 1);

    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            r_state   <= c_IDLE;
            r_half    <= '0;
            r_frame   <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_cpu_int <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_half    <= w_half_nxt;
            r_frame   <= w_frame_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_cpu_int <= w_cpu_int_nxt;
            r_wr_en   <= w_wr;
            if (w_wr) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_dat;
            end
        end
    end

`ifdef SCHED_OVERRUN_EN
    logic r_overrun;

    // A fresh overrun wins over a simultaneous clear.
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= (r_overrun & ~clr_ovr) | w_ovr_evt;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_ovr ^ w_ovr_evt;
    assign overrun      = 1'b0;
`endif

    assign wr_en   = r_wr_en;
    assign wr_bank = r_wr_bank;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_bank = r_rd_bank;
    assign cpu_int = r_cpu_int;

endmodule
`default_nettype wire

// File: tb/tb_tdm_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_buffer_scheduler
// Description : Self-checking bench for tdm_buffer_scheduler (table, directed
//               and random stimulus against a frame-level reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_buffer_scheduler;

    localparam int NF = 16;
    localparam int B  = 32;
    localparam int AW = $clog2(NF*B);

    localparam int OP_EDGES  = 0;
    localparam int OP_F0LOW  = 1;
    localparam int OP_F0HIGH = 2;
    localparam int OP_ACK    = 3;
    localparam int OP_CLR    = 4;

    logic          clk50 = 1'b0;
    logic          reset_in_rg = 1'b1;
    logic          c4 = 1'b0;
    logic          f0 = 1'b0;
    logic          data_from_dt = 1'b0;
    logic          rd_ack = 1'b0;
    logic          clr_ovr = 1'b0;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          rd_bank;
    logic          cpu_int;
    logic          overrun;

    always #10 clk50 = ~clk50;

    tdm_buffer_scheduler #(
        .NUM_FRAMES     (NF),
        .BITS_PER_FRAME (B)
    ) u_dut (
        .clk50        (clk50),
        .reset_in_rg  (reset_in_rg),
        .c4           (c4),
        .f0           (f0),
        .data_from_dt (data_from_dt),
        .rd_ack       (rd_ack),
        .clr_ovr      (clr_ovr),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_bank      (rd_bank),
        .cpu_int      (cpu_int),
        .overrun      (overrun)
    );

    typedef struct {
        bit bank;
        int addr;
        bit data;
    } wr_t;

    typedef struct {
        int op;
        int n;
        int exp_wr;
        int exp_last;
        bit wb;
        bit rb;
        bit ci;
        bit ov;
    } row_t;

    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_wr_seen = 0;
    int   last_addr = -1;

    // Reference model: position in frame counted in c4 edges (a frame is
    // 2*B-1 edges, writes on even positions), frame index, bank bookkeeping.
    bit   m_f0;
    int   m_k;
    int   m_frame;
    bit   m_bank;
    bit   m_rd;
    bit   m_int;
    bit   m_ovr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk50) begin
        wr_t e;
        #1;
        if (wr_en === 1'b1) begin
            n_wr_seen++;
            last_addr = int'(wr_addr);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", wr_addr);
            end else begin
                e = exp_q.pop_front();
                chk("write_bank", {31'd0, wr_bank}, {31'd0, e.bank});
                chk("write_addr", {{(32-AW){1'b0}}, wr_addr}, e.addr);
                chk("write_data", {31'd0, wr_data}, {31'd0, e.data});
            end
        end
    end

    task automatic m_reset();
        exp_q.delete();
        m_k = 0; m_frame = 0; m_bank = 0; m_rd = 0; m_int = 0; m_ovr = 0;
    endtask

    task automatic m_handover();
`ifdef SCHED_OVERRUN_EN
        if (m_int) begin
            m_ovr = 1;
            return;
        end
`endif
        m_rd   = m_bank;
        m_bank = ~m_bank;
        m_int  = 1;
    endtask

    task automatic m_edge(input bit d);
        wr_t e;
        if (!m_f0) return;
        if (m_k % 2 == 0) begin
            e.bank = m_bank;
            e.addr = m_frame * B + m_k / 2;
            e.data = d;
            exp_q.push_back(e);
        end
        m_k++;
        if (m_k == 2*B - 1) begin
            m_k = 0;
            m_frame++;
            if (m_frame == NF) begin
                m_frame = 0;
                m_handover();
            end
        end
    endtask

    task automatic drive_edge(input bit d, input int hi, input int lo);
        m_edge(d);
        @(negedge clk50);
        c4 = 1'b1;
        data_from_dt = d;
        repeat (hi) @(negedge clk50);
        c4 = 1'b0;
        repeat (lo) @(negedge clk50);
    endtask

    task automatic run_edges(input int n, input bit pattern);
        bit d;
        for (int i = 0; i < n; i++) begin
            d = pattern ? bit'(((m_k / 2) % 2) == 0) : bit'($urandom_range(0, 1));
            drive_edge(d, 2, 2);
        end
    endtask

    task automatic pulse_ack();
        m_int = 0;
        @(negedge clk50);
        rd_ack = 1'b1;
        @(negedge clk50);
        rd_ack = 1'b0;
    endtask

    task automatic pulse_clr();
`ifdef SCHED_OVERRUN_EN
        m_ovr = 0;
`endif
        @(negedge clk50);
        clr_ovr = 1'b1;
        @(negedge clk50);
        clr_ovr = 1'b0;
    endtask

    task automatic set_f0(input bit v);
        m_f0 = v;
        if (!v) m_k = 0;
        @(negedge clk50);
        f0 = v;
        repeat (3) @(negedge clk50);
    endtask

    task automatic chk_status();
        chk("wr_bank", {31'd0, wr_bank}, {31'd0, m_bank});
        chk("rd_bank", {31'd0, rd_bank}, {31'd0, m_rd});
        chk("cpu_int", {31'd0, cpu_int}, {31'd0, m_int});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    task automatic do_reset(input bit f0_val);
        @(negedge clk50);
        reset_in_rg = 1'b1;
        c4 = 1'b0; rd_ack = 1'b0; clr_ovr = 1'b0;
        f0 = f0_val; m_f0 = f0_val;
        m_reset();
        @(posedge clk50);
        #1;
        chk("rst_wr_en",   {31'd0, wr_en},   0);
        chk("rst_wr_addr", {{(32-AW){1'b0}}, wr_addr}, 0);
        chk("rst_wr_data", {31'd0, wr_data}, 0);
        chk("rst_wr_bank", {31'd0, wr_bank}, 0);
        chk("rst_rd_bank", {31'd0, rd_bank}, 0);
        chk("rst_cpu_int", {31'd0, cpu_int}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        @(negedge clk50);
        reset_in_rg = 1'b0;
        repeat (3) @(negedge clk50);
    endtask

    row_t tbl[11];

    initial begin
        int base;
        int r;

        tbl[0]  = '{OP_EDGES, 63,  32, 31, 0, 0, 0, 0};
        tbl[1]  = '{OP_EDGES, 20,  10, 41, 0, 0, 0, 0};
        tbl[2]  = '{OP_F0LOW, 0,   0,  -1, 0, 0, 0, 0};
        tbl[3]  = '{OP_F0HIGH, 0,  0,  -1, 0, 0, 0, 0};
        tbl[4]  = '{OP_EDGES, 63,  32, 63, 0, 0, 0, 0};
        tbl[5]  = '{OP_EDGES, 882, 448, 511, 1, 0, 1, 0};
`ifdef SCHED_OVERRUN_EN
        tbl[6]  = '{OP_EDGES, 1008, 512, 511, 1, 0, 1, 1};
        tbl[7]  = '{OP_CLR,   0,    0,   -1,  1, 0, 1, 0};
        tbl[8]  = '{OP_ACK,   0,    0,   -1,  1, 0, 0, 0};
        tbl[9]  = '{OP_ACK,   0,    0,   -1,  1, 0, 0, 0};
        tbl[10] = '{OP_EDGES, 1,    1,   0,   1, 0, 0, 0};
`else
        tbl[6]  = '{OP_EDGES, 1008, 512, 511, 0, 1, 1, 0};
        tbl[7]  = '{OP_CLR,   0,    0,   -1,  0, 1, 1, 0};
        tbl[8]  = '{OP_ACK,   0,    0,   -1,  0, 1, 0, 0};
        tbl[9]  = '{OP_ACK,   0,    0,   -1,  0, 1, 0, 0};
        tbl[10] = '{OP_EDGES, 1,    1,   0,   0, 1, 0, 0};
`endif

        // Write strobe lands exactly three clk50 cycles after the c4 rise.
        do_reset(1'b1);
        m_edge(1'b1);
        @(negedge clk50);
        c4 = 1'b1;
        data_from_dt = 1'b1;
        @(posedge clk50); #1; chk("latency_cycle1", {31'd0, wr_en}, 0);
        @(posedge clk50); #1; chk("latency_cycle2", {31'd0, wr_en}, 0);
        @(posedge clk50); #1; chk("latency_cycle3", {31'd0, wr_en}, 1);
        @(posedge clk50); #1; chk("pulse_width",    {31'd0, wr_en}, 0);
        @(negedge clk50);
        c4 = 1'b0;
        repeat (3) @(negedge clk50);

        do_reset(1'b1);
        for (int i = 0; i < 11; i++) begin
            base = n_wr_seen;
            case (tbl[i].op)
                OP_EDGES:  run_edges(tbl[i].n, 1'b1);
                OP_F0LOW:  set_f0(1'b0);
                OP_F0HIGH: set_f0(1'b1);
                OP_ACK:    pulse_ack();
                default:   pulse_clr();
            endcase
            chk($sformatf("row%0d_writes", i), n_wr_seen - base, tbl[i].exp_wr);
            if (tbl[i].exp_last >= 0)
                chk($sformatf("row%0d_last_addr", i), last_addr, tbl[i].exp_last);
            chk($sformatf("row%0d_wr_bank", i), {31'd0, wr_bank}, {31'd0, tbl[i].wb});
            chk($sformatf("row%0d_rd_bank", i), {31'd0, rd_bank}, {31'd0, tbl[i].rb});
            chk($sformatf("row%0d_cpu_int", i), {31'd0, cpu_int}, {31'd0, tbl[i].ci});
            chk($sformatf("row%0d_overrun", i), {31'd0, overrun}, {31'd0, tbl[i].ov});
        end

        // Acknowledge landing in the handover cycle, then reset mid-frame.
        do_reset(1'b1);
        run_edges(NF*(2*B-1), 1'b0);
        run_edges(NF*(2*B-1) - 1, 1'b0);
        m_int = 0;
        m_edge(1'b1);
        @(negedge clk50);
        c4 = 1'b1;
        data_from_dt = 1'b1;
        repeat (3) @(posedge clk50);
        #1 rd_ack = 1'b1;
        @(posedge clk50);
        #1 rd_ack = 1'b0;
        @(negedge clk50);
        c4 = 1'b0;
        repeat (3) @(negedge clk50);
        chk("coinc_overrun", {31'd0, overrun}, 0);
        chk("coinc_wr_bank", {31'd0, wr_bank}, 0);
        chk("coinc_rd_bank", {31'd0, rd_bank}, 1);
        chk("coinc_cpu_int", {31'd0, cpu_int}, 1);
        chk_status();
        run_edges(7*(2*B-1) + 31, 1'b0);
        chk("mid_frame_last_addr", last_addr, 7*B + 15);
        do_reset(1'b1);
        run_edges(1, 1'b0);
        chk("post_reset_addr", last_addr, 0);
        chk_status();

        // Randomized traffic against the reference model.
        do_reset(1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (!m_f0 && r < 200) begin
                set_f0(1'b1);
            end else if (r < 900) begin
                drive_edge(bit'($urandom_range(0, 1)), $urandom_range(2, 4), $urandom_range(2, 4));
            end else if (r < 903) begin
                set_f0(1'b0);
            end else if (r < 908) begin
                pulse_ack();
            end else if (r < 914) begin
                pulse_clr();
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk50);
            end
            if (i % 50 == 49) chk_status();
        end
        repeat (6) @(negedge clk50);
        chk_status();
        chk("expected_writes_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
